decode_stage_rv: RTL and testbench

Registered RV32I(+M) instruction-decode stage that generalises the single-cycle decoder into a flow-controlled pipeline stage. It accepts fetched instructions with their PC over a valid/ready handshake and produces a fully decoded bundle one cycle later: operation code, register indices with use flags, sign-extended immediate and illegal-instruction flag. A 2-entry output buffer decouples fetch from execute, and a flush input discards in-flight work on redirect. It sits between fetch and the register-file/ALU issue logic.

---
 rtl/decode_pkg.sv | 97 +++++++++
 rtl/imm_gen_rv.sv | 18 +
 rtl/decode_stage_rv.sv | 213 +++++++++++++++++++++
 tb/tb_decode_stage_rv.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: operation codes, opcode constants, immediate formats and the decoded bundle
package decode_pkg;

  typedef enum logic [5:0] {
    OP_NOP,
    OP_ILLEGAL,
    OP_LUI,
    OP_AUIPC,
    OP_JAL,
    OP_JALR,
    OP_BEQ,
    OP_BNE,
    OP_BLT,
    OP_BGE,
    OP_BLTU,
    OP_BGEU,
    OP_LB,
    OP_LH,
    OP_LW,
    OP_LBU,
    OP_LHU,
    OP_SB,
    OP_SH,
    OP_SW,
    OP_ADDI,
    OP_SLTI,
    OP_SLTIU,
    OP_XORI,
    OP_ORI,
    OP_ANDI,
    OP_SLLI,
    OP_SRLI,
    OP_SRAI,
    OP_ADD,
    OP_SLL,
    OP_SLT,
    OP_SLTU,
    OP_XOR,
    OP_SRL,
    OP_OR,
    OP_AND,
    OP_SUB,
    OP_SRA,
    OP_FENCE,
    OP_ECALL,
    OP_EBREAK,
    OP_MUL,
    OP_MULH,
    OP_MULHSU,
    OP_MULHU,
    OP_DIV,
    OP_DIVU,
    OP_REM,
    OP_REMU
  } op_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_SHAMT
  } imm_fmt_e;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    op_e         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rd_we;
    logic        rs1_used;
    logic        rs2_used;
    logic [31:0] imm;
    logic [9:0]  funct7_funct3;
    logic [31:0] pc;
    logic        illegal;
  } bundle_t;

endpackage

// File: rtl/imm_gen_rv.sv
// imm_gen_rv: sign-extended immediate for the selected RV32I instruction format
module imm_gen_rv
  import decode_pkg::*;
(
  input  logic [31:7] instr,
  input  imm_fmt_e    fmt,
  output logic [31:0] imm
);

  assign imm = fmt == IMM_I     ? {{20{instr[31]}}, instr[31:20]} :
               fmt == IMM_S     ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
               fmt == IMM_B     ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
               fmt == IMM_U     ? {instr[31:12], 12'b0} :
               fmt == IMM_J     ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
               fmt == IMM_SHAMT ? {27'b0, instr[24:20]} :
                                  32'b0;

endmodule

// File: rtl/decode_stage_rv.sv
// decode_stage_rv: registered RV32I(+M) decode stage with a 2-entry output buffer and flush
module decode_stage_rv
  import decode_pkg::*;
#(
  parameter bit          EN_M  = 1'b0,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      pc,
  output logic             out_valid,
  input  logic             out_ready,
  output op_e              out_op,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic             out_rd_we,
  output logic             out_rs1_used,
  output logic             out_rs2_used,
  output logic [31:0]      out_imm,
  output logic [9:0]       out_funct7_funct3,
  output logic [31:0]      out_pc,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  op_e         op;
  imm_fmt_e    fmt;
  logic        we;
  logic        u1;
  logic        u2;
  logic        ill;
  logic [31:0] imm;
  bundle_t     dec;
  bundle_t     head;
  bundle_t     tail;
  logic [1:0]  count;
  logic        push;
  logic        pop;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  // classify the encoding: operation, immediate format and register usage before legality gating
  always_comb begin
    op  = OP_ILLEGAL;
    fmt = IMM_NONE;
    we  = 1'b0;
    u1  = 1'b0;
    u2  = 1'b0;
    case (opc)
      OPC_LUI: begin
        op  = OP_LUI;
        fmt = IMM_U;
        we  = 1'b1;
      end
      OPC_AUIPC: begin
        op  = OP_AUIPC;
        fmt = IMM_U;
        we  = 1'b1;
      end
      OPC_JAL: begin
        op  = OP_JAL;
        fmt = IMM_J;
        we  = 1'b1;
      end
      OPC_JALR: begin
        op  = f3 == 3'd0 ? OP_JALR : OP_ILLEGAL;
        fmt = IMM_I;
        we  = 1'b1;
        u1  = 1'b1;
      end
      OPC_BRANCH: begin
        case (f3)
          3'd0:    op = OP_BEQ;
          3'd1:    op = OP_BNE;
          3'd4:    op = OP_BLT;
          3'd5:    op = OP_BGE;
          3'd6:    op = OP_BLTU;
          3'd7:    op = OP_BGEU;
          default: op = OP_ILLEGAL;
        endcase
        fmt = IMM_B;
        u1  = 1'b1;
        u2  = 1'b1;
      end
      OPC_LOAD: begin
        case (f3)
          3'd0:    op = OP_LB;
          3'd1:    op = OP_LH;
          3'd2:    op = OP_LW;
          3'd4:    op = OP_LBU;
          3'd5:    op = OP_LHU;
          default: op = OP_ILLEGAL;
        endcase
        fmt = IMM_I;
        we  = 1'b1;
        u1  = 1'b1;
      end
      OPC_STORE: begin
        case (f3)
          3'd0:    op = OP_SB;
          3'd1:    op = OP_SH;
          3'd2:    op = OP_SW;
          default: op = OP_ILLEGAL;
        endcase
        fmt = IMM_S;
        u1  = 1'b1;
        u2  = 1'b1;
      end
      OPC_OPIMM: begin
        case (f3)
          3'd0:    op = OP_ADDI;
          3'd1:    op = f7 == F7_BASE ? OP_SLLI : OP_ILLEGAL;
          3'd2:    op = OP_SLTI;
          3'd3:    op = OP_SLTIU;
          3'd4:    op = OP_XORI;
          3'd5:    op = f7 == F7_BASE ? OP_SRLI : f7 == F7_ALT ? OP_SRAI : OP_ILLEGAL;
          3'd6:    op = OP_ORI;
          default: op = OP_ANDI;
        endcase
        fmt = f3 == 3'd1 || f3 == 3'd5 ? IMM_SHAMT : IMM_I;
        we  = 1'b1;
        u1  = 1'b1;
      end
      OPC_OP: begin
        if (f7 == F7_BASE) op = op_e'(OP_ADD + 6'(f3));
        else if (f7 == F7_ALT && f3 == 3'd0) op = OP_SUB;
        else if (f7 == F7_ALT && f3 == 3'd5) op = OP_SRA;
        else if (f7 == F7_MULDIV && EN_M) op = op_e'(OP_MUL + 6'(f3));
        we = 1'b1;
        u1 = 1'b1;
        u2 = 1'b1;
      end
      OPC_MISC_MEM: op = f3 == 3'd0 ? OP_FENCE : OP_ILLEGAL;
      OPC_SYSTEM: begin
        op = instr[31:7] == 25'd0                  ? OP_ECALL  :
             instr[31:7] == {12'h001, 13'h0000}    ? OP_EBREAK :
                                                     OP_ILLEGAL;
      end
      default: op = OP_ILLEGAL;
    endcase
  end

  assign ill = op == OP_ILLEGAL;

  imm_gen_rv u_imm (
    .instr (instr[31:7]),
    .fmt   (ill ? IMM_NONE : fmt),
    .imm   (imm)
  );

  // assemble the bundle; an illegal encoding carries no register usage, immediate or funct fields
  always_comb begin
    dec.op            = op;
    dec.rd            = instr[11:7];
    dec.rs1           = instr[19:15];
    dec.rs2           = instr[24:20];
    dec.rd_we         = we && !ill && instr[11:7] != 5'd0;
    dec.rs1_used      = u1 && !ill;
    dec.rs2_used      = u2 && !ill;
    dec.imm           = imm;
    dec.funct7_funct3 = opc == OPC_OP && !ill ? {f7, f3} : 10'd0;
    dec.pc            = pc;
    dec.illegal       = ill;
  end

  assign in_ready  = count != 2'd2 && !rst;
  assign out_valid = count != 2'd0;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  // two-entry buffer: head drives the outputs, tail shifts up on pop; flush empties it like reset
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      count <= count + 2'(push) - 2'(pop);
      if (pop) head <= count == 2'd2 ? tail : push ? dec : '0;
      else if (push && count == 2'd0) head <= dec;
      if (push && !pop && count == 2'd1) tail <= dec;
    end
  end

  // saturating count of illegal bundles taken by the consumer
  always_ff @(posedge clk) begin
    if (rst) illegal_cnt <= '0;
    else if (pop && head.illegal && !(&illegal_cnt)) illegal_cnt <= illegal_cnt + CNT_W'(1);
  end

  assign out_op            = head.op;
  assign out_rd            = head.rd;
  assign out_rs1           = head.rs1;
  assign out_rs2           = head.rs2;
  assign out_rd_we         = head.rd_we;
  assign out_rs1_used      = head.rs1_used;
  assign out_rs2_used      = head.rs2_used;
  assign out_imm           = head.imm;
  assign out_funct7_funct3 = head.funct7_funct3;
  assign out_pc            = head.pc;
  assign out_illegal       = head.illegal;

endmodule

// File: tb/tb_decode_stage_rv.sv
// tb_decode_stage_rv: scoreboard bench driving an EN_M=0 and an EN_M=1 instance in lockstep
module tb_decode_stage_rv;
  import decode_pkg::*;

  typedef struct packed {
    logic [31:0] instr;
    op_e         op0;
    op_e         op1;
    logic        we;
    logic        u1;
    logic        u2;
    logic [31:0] imm;
    logic [9:0]  f73;
  } vec_t;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] pc;
  } item_t;

  localparam int NV = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;

  logic [1:0]  in_ready, out_valid, rd_we, rs1_used, rs2_used, illegal;
  logic [5:0]  op [2];
  logic [4:0]  rd [2];
  logic [4:0]  rs1 [2];
  logic [4:0]  rs2 [2];
  logic [31:0] imm [2];
  logic [31:0] opc [2];
  logic [9:0]  f73 [2];
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  int    n_chk = 0;
  int    n_err = 0;
  int    exp_cnt0 = 0;
  int    exp_cnt1 = 0;
  int    cyc = 0;
  logic  rnd_bp = 1'b0;
  logic [31:0] pc_next = 32'h1000;
  item_t sb [$];
  item_t it;

  decode_stage_rv #(.EN_M(1'b0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[0]),
    .instr(instr), .pc(pc), .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_op(op[0]), .out_rd(rd[0]), .out_rs1(rs1[0]), .out_rs2(rs2[0]),
    .out_rd_we(rd_we[0]), .out_rs1_used(rs1_used[0]), .out_rs2_used(rs2_used[0]),
    .out_imm(imm[0]), .out_funct7_funct3(f73[0]), .out_pc(opc[0]),
    .out_illegal(illegal[0]), .illegal_cnt(cnt0)
  );

  decode_stage_rv #(.EN_M(1'b1), .CNT_W(2)) dut_m (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[1]),
    .instr(instr), .pc(pc), .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_op(op[1]), .out_rd(rd[1]), .out_rs1(rs1[1]), .out_rs2(rs2[1]),
    .out_rd_we(rd_we[1]), .out_rs1_used(rs1_used[1]), .out_rs2_used(rs2_used[1]),
    .out_imm(imm[1]), .out_funct7_funct3(f73[1]), .out_pc(opc[1]),
    .out_illegal(illegal[1]), .illegal_cnt(cnt1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (rnd_bp) #1 out_ready = 1'($urandom_range(0, 1));

  function automatic vec_t vec(input int i);
    case (i)
      0:  return '{32'hFFF10093, OP_ADDI,    OP_ADDI,   1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 10'h000};
      1:  return '{32'hFE208EE3, OP_BEQ,     OP_BEQ,    1'b0, 1'b1, 1'b1, 32'hFFFFFFFC, 10'h000};
      2:  return '{32'h123452B7, OP_LUI,     OP_LUI,    1'b1, 1'b0, 1'b0, 32'h12345000, 10'h000};
      3:  return '{32'h022081B3, OP_ILLEGAL, OP_MUL,    1'b1, 1'b1, 1'b1, 32'h00000000, 10'h008};
      4:  return '{32'h40628233, OP_SUB,     OP_SUB,    1'b1, 1'b1, 1'b1, 32'h00000000, 10'h100};
      5:  return '{32'h40545393, OP_SRAI,    OP_SRAI,   1'b1, 1'b1, 1'b0, 32'h00000005, 10'h000};
      6:  return '{32'hFE952C23, OP_SW,      OP_SW,     1'b0, 1'b1, 1'b1, 32'hFFFFFFF8, 10'h000};
      7:  return '{32'h001000EF, OP_JAL,     OP_JAL,    1'b1, 1'b0, 1'b0, 32'h00000800, 10'h000};
      8:  return '{32'h00000073, OP_ECALL,   OP_ECALL,  1'b0, 1'b0, 1'b0, 32'h00000000, 10'h000};
      9:  return '{32'hFFFFFFFF, OP_ILLEGAL, OP_ILLEGAL,1'b0, 1'b0, 1'b0, 32'h00000000, 10'h000};
      10: return '{32'h0040A003, OP_LW,      OP_LW,     1'b0, 1'b1, 1'b0, 32'h00000004, 10'h000};
      11: return '{32'h80000117, OP_AUIPC,   OP_AUIPC,  1'b1, 1'b0, 1'b0, 32'h80000000, 10'h000};
      12: return '{32'h027352B3, OP_ILLEGAL, OP_DIVU,   1'b1, 1'b1, 1'b1, 32'h00000000, 10'h00D};
      13: return '{32'h4062C233, OP_ILLEGAL, OP_ILLEGAL,1'b0, 1'b0, 1'b0, 32'h00000000, 10'h000};
      14: return '{32'h40109093, OP_ILLEGAL, OP_ILLEGAL,1'b0, 1'b0, 1'b0, 32'h00000000, 10'h000};
      15: return '{32'h00002063, OP_ILLEGAL, OP_ILLEGAL,1'b0, 1'b0, 1'b0, 32'h00000000, 10'h000};
      16: return '{32'h0FF0000F, OP_FENCE,   OP_FENCE,  1'b0, 1'b0, 1'b0, 32'h00000000, 10'h000};
      17: return '{32'h00100073, OP_EBREAK,  OP_EBREAK, 1'b0, 1'b0, 1'b0, 32'h00000000, 10'h000};
      18: return '{32'h7FF23193, OP_SLTIU,   OP_SLTIU,  1'b1, 1'b1, 1'b0, 32'h000007FF, 10'h000};
      default: return '{32'h003150B3, OP_SRL, OP_SRL,   1'b1, 1'b1, 1'b1, 32'h00000000, 10'h005};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cmp(input item_t t);
    vec_t v;
    op_e  e;
    logic il;
    v = vec(int'(t.idx));
    for (int c = 0; c < 2; c++) begin
      e  = c == 0 ? v.op0 : v.op1;
      il = e == OP_ILLEGAL;
      check($sformatf("op%0d_i%0d", c, t.idx), 32'(op[c]), 32'(e));
      check($sformatf("ill%0d_i%0d", c, t.idx), 32'(illegal[c]), 32'(il));
      check($sformatf("rd%0d_i%0d", c, t.idx), 32'(rd[c]), 32'(v.instr[11:7]));
      check($sformatf("rs1_%0d_i%0d", c, t.idx), 32'(rs1[c]), 32'(v.instr[19:15]));
      check($sformatf("rs2_%0d_i%0d", c, t.idx), 32'(rs2[c]), 32'(v.instr[24:20]));
      check($sformatf("we%0d_i%0d", c, t.idx), 32'(rd_we[c]), 32'(il ? 1'b0 : v.we));
      check($sformatf("u1_%0d_i%0d", c, t.idx), 32'(rs1_used[c]), 32'(il ? 1'b0 : v.u1));
      check($sformatf("u2_%0d_i%0d", c, t.idx), 32'(rs2_used[c]), 32'(il ? 1'b0 : v.u2));
      check($sformatf("imm%0d_i%0d", c, t.idx), imm[c], il ? 32'd0 : v.imm);
      check($sformatf("f73_%0d_i%0d", c, t.idx), 32'(f73[c]), 32'(il ? 10'd0 : v.f73));
      check($sformatf("pc%0d_i%0d", c, t.idx), opc[c], t.pc);
    end
    check("icnt0", 32'(cnt0), 32'(exp_cnt0));
    check("icnt1", 32'(cnt1), 32'(exp_cnt1));
    if (v.op0 == OP_ILLEGAL) exp_cnt0++;
    if (v.op1 == OP_ILLEGAL && exp_cnt1 < 3) exp_cnt1++;
  endtask

  // pop the scoreboard whenever a bundle is handed to the consumer
  always @(negedge clk) begin
    if (!rst && out_valid[0] && out_ready) begin
      if (sb.size() == 0) check("extra_out", 32'(out_valid), 32'd0);
      else begin
        it = sb.pop_front();
        cmp(it);
      end
    end
  end

  task automatic send(input int idx);
    int n;
    vec_t v;
    n = 0;
    v = vec(idx);
    in_valid = 1'b1;
    instr = v.instr;
    pc = pc_next;
    @(negedge clk);
    while (!in_ready[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept", 32'(in_ready), 32'd3);
    if (in_ready[0]) sb.push_back('{5'(idx), pc_next});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pc_next += 32'd4;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    exp_cnt0 = 0;
    exp_cnt1 = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    repeat (2) @(negedge clk);
    check("rst_in_ready0", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_op", 32'(op[0]), 32'(OP_NOP));
    check("rst_imm", imm[0], 32'd0);
    check("rst_cnt0", 32'(cnt0), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(in_ready), 32'd3);
    @(posedge clk);
    #1;
    send(0);
    @(negedge clk);
    check("latency", 32'(out_valid), 32'd3);
    out_ready = 1'b1;
    drain();
    t0 = cyc;
    for (int i = 0; i < NV; i++) send(i);
    check("throughput", 32'(cyc - t0), 32'(NV));
    drain();
    out_ready = 1'b0;
    send(4);
    send(6);
    in_valid = 1'b1;
    instr = vec(5).instr;
    pc = pc_next;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_full", 32'(in_ready), 32'd0);
      check("bp_hold_pc", opc[0], sb[0].pc);
      check("bp_hold_op", 32'(op[0]), 32'(OP_SUB));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(5);
    drain();
    out_ready = 1'b0;
    send(2);
    send(9);
    in_valid = 1'b1;
    instr = vec(0).instr;
    pc = 32'hDEAD0000;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush2_valid", 32'(out_valid), 32'd0);
    check("flush2_ready", 32'(in_ready), 32'd3);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(1);
    in_valid = 1'b1;
    instr = vec(3).instr;
    pc = 32'hBEEF0000;
    flush = 1'b1;
    @(negedge clk);
    check("flush1_ready", 32'(in_ready), 32'd3);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush1_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    do_reset();
    repeat (5) send(9);
    drain();
    @(negedge clk);
    check("cnt_five", 32'(cnt0), 32'd5);
    check("cnt_sat", 32'(cnt1), 32'd3);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(0);
    send(7);
    do_reset();
    @(negedge clk);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_cnt0", 32'(cnt0), 32'd0);
    check("midrst_cnt1", 32'(cnt1), 32'd0);
    check("midrst_op", 32'(op[0]), 32'(OP_NOP));
    check("midrst_ready", 32'(in_ready), 32'd3);
    @(posedge clk);
    #1;
    rnd_bp = 1'b1;
    for (int i = 0; i < NV; i++) send(NV - 1 - i);
    rnd_bp = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
